fifo_access_scheduler: RTL and testbench

//  Sequences the shared 8-bit single-clock FIFO: two producers are round-robin arbitrated onto the

---
 rtl/fifo_sched_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 51 +++++
 rtl/fifo_access_scheduler.sv | 104 ++++++++++
 tb/tb_fifo_access_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared build-time constants and types for the FIFO access scheduler.
// DEPTH must match the FIFO instance that the scheduler drives.
package fifo_sched_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 4;
  localparam int MAX_BURST  = 2;
  localparam int LEVEL_W    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-producer round-robin arbiter with a burst limit for the FIFO write port.
// Grant only moves while the FIFO can accept, so a full FIFO freezes arbitration.
module rr_arbiter2
  import fifo_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  input  logic       can_write,
  output logic       grant,
  output logic [1:0] ready,
  output logic       write
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  logic               grant_q, grant_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               own_valid, other_valid, burst_done, toggle;

  always_comb begin
    ready       = {grant_q & can_write, ~grant_q & can_write};
    own_valid   = req_valid[grant_q];
    other_valid = req_valid[~grant_q];
    write       = own_valid & can_write;
    // this write is the one that brings the burst count up to the limit
    burst_done  = write & (burst_cnt_q >= BURST_W'(MAX_BURST - 1));
    toggle      = can_write & other_valid & (~own_valid | burst_done);

    grant_d     = grant_q ^ toggle;
    burst_cnt_d = burst_cnt_q;
    if (toggle) begin
      burst_cnt_d = '0;
    end else if (write && (burst_cnt_q < BURST_W'(MAX_BURST))) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_q     <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: rtl/fifo_access_scheduler.sv
// Arbitrates two producers onto a shared FIFO write port and drains the read port
// one byte at a time into a registered valid/ready output stage.
module fifo_access_scheduler
  import fifo_sched_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  fifo_write_en,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  fifo_read_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [LEVEL_W-1:0]    level
);

  rd_state_e             state_q, state_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  can_write, grant, write, data_avail;
  logic [1:0]            ready;

  assign can_write  = (level_q < LEVEL_W'(DEPTH)) & ~fifo_full;
  assign data_avail = (level_q != '0) & ~fifo_empty;

  rr_arbiter2 u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid ({req1_valid, req0_valid}),
    .can_write (can_write),
    .grant     (grant),
    .ready     (ready),
    .write     (write)
  );

  assign req0_ready    = ready[0];
  assign req1_ready    = ready[1];
  assign fifo_write_en = write;
  assign fifo_data_in  = grant ? req1_data : req0_data;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    fifo_read_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_avail) state_d = POP;
      end
      POP: begin
        // read data is only valid during the strobe, so capture it here
        fifo_read_en = 1'b1;
        out_data_d   = fifo_data_out;
        out_valid_d  = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = data_avail ? POP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({write, fifo_read_en})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Randomized bench for fifo_access_scheduler: a queue-based FIFO model drives the FIFO
// side, and a behavioural model plus an in-order scoreboard predict every output.
module tb_fifo_access_scheduler;
  import fifo_sched_pkg::*;

  localparam int PH_IDLE = 0;
  localparam int PH_POP  = 1;
  localparam int PH_HOLD = 2;

  logic                  clock;
  logic                  reset_n;
  logic                  req0_valid, req1_valid;
  logic [DATA_WIDTH-1:0] req0_data, req1_data;
  logic                  req0_ready, req1_ready;
  logic                  fifo_write_en, fifo_read_en;
  logic [DATA_WIDTH-1:0] fifo_data_in, fifo_data_out;
  logic                  fifo_full, fifo_empty;
  logic                  out_valid, out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LEVEL_W-1:0]    level;

  int checkCount = 0;
  int passCount  = 0;

  // reference model state
  int                    mGrant, mBurst, mLevel, mPhase;
  logic                  mOutValid;
  logic [DATA_WIDTH-1:0] mOutData;
  logic [DATA_WIDTH-1:0] fifoQ[$];
  logic [DATA_WIDTH-1:0] sbQ[$];

  fifo_access_scheduler dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_read_en  (fifo_read_en),
    .fifo_data_out (fifo_data_out),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .level         (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    else
      passCount++;
  endtask

  task automatic driveFifo();
    fifo_full     = (fifoQ.size() == DEPTH);
    fifo_empty    = (fifoQ.size() == 0);
    fifo_data_out = (fifoQ.size() > 0) ? fifoQ[0] : '0;
  endtask

  task automatic resetModel();
    mGrant    = 0;
    mBurst    = 0;
    mLevel    = 0;
    mPhase    = PH_IDLE;
    mOutValid = 1'b0;
    mOutData  = '0;
    fifoQ.delete();
    sbQ.delete();
    driveFifo();
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the model after the rise.
  task automatic applyStimulus(input logic v0, input logic v1, input logic [7:0] d0,
                               input logic [7:0] d1, input logic ordy);
    bit   canW, wr, popNow, ownV, othV;
    logic [7:0] wrData, expByte;
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = d0;
    req1_data  = d1;
    out_ready  = ordy;
    @(negedge clock);
    canW   = (mLevel < DEPTH);
    ownV   = (mGrant == 0) ? v0 : v1;
    othV   = (mGrant == 0) ? v1 : v0;
    wr     = ownV && canW;
    wrData = (mGrant == 0) ? d0 : d1;
    popNow = (mPhase == PH_POP);
    checkOutput("req0_ready", req0_ready, (mGrant == 0) && canW);
    checkOutput("req1_ready", req1_ready, (mGrant == 1) && canW);
    checkOutput("write_en", fifo_write_en, wr);
    if (wr) checkOutput("data_in", fifo_data_in, wrData);
    checkOutput("read_en", fifo_read_en, popNow);
    checkOutput("out_valid", out_valid, mOutValid);
    checkOutput("out_data", out_data, mOutData);
    checkOutput("level", level, mLevel);
    if (mOutValid && ordy) begin
      expByte = 8'hxx;
      if (sbQ.size() > 0) expByte = sbQ.pop_front();
      checkOutput("byte_order", out_data, expByte);
    end
    @(posedge clock);
    #1;
    case (mPhase)
      PH_IDLE: if (mLevel > 0) mPhase = PH_POP;
      PH_POP: begin
        mOutData  = fifoQ.pop_front();
        mOutValid = 1'b1;
        mPhase    = PH_HOLD;
      end
      default: if (ordy) begin
        mOutValid = 1'b0;
        mPhase    = (mLevel > 0) ? PH_POP : PH_IDLE;
      end
    endcase
    if (canW && othV && (!ownV || (wr && (mBurst + 1 >= MAX_BURST)))) begin
      mGrant = 1 - mGrant;
      mBurst = 0;
    end else if (wr && mBurst < MAX_BURST) begin
      mBurst++;
    end
    if (wr) begin
      fifoQ.push_back(wrData);
      sbQ.push_back(wrData);
    end
    mLevel = mLevel + int'(wr) - int'(popNow);
    driveFifo();
  endtask

  initial begin
    bit found;
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    out_ready  = 1'b0;
    resetModel();
    #12;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_read_en", fifo_read_en, 0);
    checkOutput("rst_ready0", req0_ready, 1);
    checkOutput("rst_ready1", req1_ready, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // single producer stream, consumer always ready
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'(8'hA1 + i), 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // both producers busy, consumer stalled: burst alternation and full
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'(8'h10 + i), 8'(8'h20 + i), 1'b0);
    // consumer resumes with producer 1 still pushing
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h00, 8'(8'h30 + i), 1'b1);
    // stall in HOLD for several cycles
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    // grant hand-over to producer 1
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00, 8'(8'h40 + i), 1'b1);

    // randomized traffic with varying consumer pressure
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    8'($urandom), 8'($urandom), $urandom_range(0, 9) < (i / 100 + 2));
    end

    // reach HOLD with level 3, then reset mid-operation
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
      found = (mPhase == PH_HOLD) && (mLevel == 3);
    end
    checkOutput("hold_search", found, 1);
    reset_n = 1'b0;
    #2;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_level", level, 0);
    checkOutput("mid_rst_read_en", fifo_read_en, 0);
    resetModel();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h00, 8'(8'h50 + i), 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
